// File: rtl/serial_xfer_ctrl.sv
// serial_xfer_ctrl
//   Transaction sequencer for the 3-wire serial controller. It frames 1..MAX_WORDS
//   words under a chip select, feeds the serial block one parallel word at a time,
//   follows its next-word / word-finished pulses and collects the received words.
//
// Ports
//   in_clk            main clock
//   in_rst            asynchronous reset, active low
//   in_start          start a transaction (only looked at in Idle)
//   in_num_words      words in this transaction, latched at start (clamped to MAX_WORDS)
//   in_tx_data        tx words, word k at [k*BITS +: BITS], latched at start
//   out_rx_data       received words, same packing; unused words keep old contents
//   out_busy          high in every state except Idle
//   out_done          one-cycle pulse at the end of a transaction
//   out_cs            chip select to the slave IC (active level CS_ACTIVE)
//   out_ser_enable    -> serial in_enable
//   out_ser_parallel  -> serial in_parallel
//   in_ser_ready      <- serial out_ready          (serial clock domain)
//   in_ser_next_word  <- serial out_next_word      (serial clock domain)
//   in_ser_word_fin   <- serial out_word_finished  (serial clock domain)
//   in_ser_parallel   <- serial out_parallel, sampled only on the word-finished event
module serial_xfer_ctrl #(
    parameter int unsigned BITS            = 8,
    parameter int unsigned MAX_WORDS       = 4,
    parameter int unsigned CS_SETUP_CYCLES = 16,
    parameter int unsigned CS_HOLD_CYCLES  = 16,
    parameter bit          CS_ACTIVE       = 1'b0
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic                             in_start,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   in_num_words,
    input  logic [MAX_WORDS*BITS-1:0]        in_tx_data,
    output logic [MAX_WORDS*BITS-1:0]        out_rx_data,
    output logic                             out_busy,
    output logic                             out_done,
    output logic                             out_cs,
    output logic                             out_ser_enable,
    output logic [BITS-1:0]                  out_ser_parallel,
    input  logic                             in_ser_ready,
    input  logic                             in_ser_next_word,
    input  logic                             in_ser_word_fin,
    input  logic [BITS-1:0]                  in_ser_parallel
);

    localparam int unsigned CW      = $clog2(MAX_WORDS + 1);
    localparam int unsigned CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES
                                                                          : CS_HOLD_CYCLES;
    localparam int unsigned TW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_TRANSFER,
        S_CS_HOLD,
        S_DONE
    } state_t;

    state_t                      state, state_nx;
    logic [TW-1:0]               phase_cnt, phase_cnt_nx;
    logic [CW-1:0]               word_count, word_count_nx;
    logic [CW-1:0]               tx_idx, tx_idx_nx;
    logic [CW-1:0]               rx_idx, rx_idx_nx;
    logic [MAX_WORDS*BITS-1:0]   tx_buf, tx_buf_nx;
    logic [MAX_WORDS*BITS-1:0]   rx_data_nx;
    logic [BITS-1:0]             ser_par_nx;
    logic                        ser_en_nx;
    logic                        cs_nx;
    logic                        done_nx;

    // Serial-domain handshakes: 2-FF synchronisers, then rising-edge detect on the pulses.
    logic [1:0] ready_sync, next_sync, fin_sync;
    logic       next_prev, fin_prev;
    logic       next_ev, fin_ev;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            ready_sync <= '0;
            next_sync  <= '0;
            fin_sync   <= '0;
            next_prev  <= 1'b0;
            fin_prev   <= 1'b0;
        end else begin
            ready_sync <= {ready_sync[0], in_ser_ready};
            next_sync  <= {next_sync[0], in_ser_next_word};
            fin_sync   <= {fin_sync[0], in_ser_word_fin};
            next_prev  <= next_sync[1];
            fin_prev   <= fin_sync[1];
        end
    end

    assign next_ev  = next_sync[1] & ~next_prev;
    assign fin_ev   = fin_sync[1] & ~fin_prev;
    assign out_busy = (state != S_IDLE);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state            <= S_IDLE;
            phase_cnt        <= '0;
            word_count       <= '0;
            tx_idx           <= '0;
            rx_idx           <= '0;
            tx_buf           <= '0;
            out_rx_data      <= '0;
            out_ser_parallel <= '0;
            out_ser_enable   <= 1'b0;
            out_cs           <= ~CS_ACTIVE;
            out_done         <= 1'b0;
        end else begin
            state            <= state_nx;
            phase_cnt        <= phase_cnt_nx;
            word_count       <= word_count_nx;
            tx_idx           <= tx_idx_nx;
            rx_idx           <= rx_idx_nx;
            tx_buf           <= tx_buf_nx;
            out_rx_data      <= rx_data_nx;
            out_ser_parallel <= ser_par_nx;
            out_ser_enable   <= ser_en_nx;
            out_cs           <= cs_nx;
            out_done         <= done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        phase_cnt_nx  = phase_cnt;
        word_count_nx = word_count;
        tx_idx_nx     = tx_idx;
        rx_idx_nx     = rx_idx;
        tx_buf_nx     = tx_buf;
        rx_data_nx    = out_rx_data;
        ser_par_nx    = out_ser_parallel;
        ser_en_nx     = out_ser_enable;
        cs_nx         = out_cs;
        done_nx       = 1'b0;

        case (state)
            S_IDLE: begin
                if (in_start) begin
                    if (in_num_words == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        word_count_nx = (in_num_words > CW'(MAX_WORDS)) ? CW'(MAX_WORDS)
                                                                        : in_num_words;
                        tx_buf_nx     = in_tx_data;
                        tx_idx_nx     = '0;
                        rx_idx_nx     = '0;
                        ser_par_nx    = in_tx_data[BITS-1:0];
                        cs_nx         = CS_ACTIVE;
                        phase_cnt_nx  = '0;
                        state_nx      = S_CS_SETUP;
                    end
                end
            end

            S_CS_SETUP: begin
                if (phase_cnt == TW'(CS_SETUP_CYCLES - 1)) begin
                    phase_cnt_nx = '0;
                    ser_en_nx    = 1'b1;
                    state_nx     = S_TRANSFER;
                end else begin
                    phase_cnt_nx = phase_cnt + TW'(1);
                end
            end

            S_TRANSFER: begin
                // next_word marks the serial block having taken the current word; the
                // following word must be presented before that one finishes shifting.
                if (next_ev) begin
                    if (tx_idx == word_count - CW'(1)) begin
                        ser_en_nx = 1'b0;
                    end else begin
                        tx_idx_nx = tx_idx + CW'(1);
                        for (int unsigned k = 0; k < MAX_WORDS; k++) begin
                            if (tx_idx + CW'(1) == CW'(k)) begin
                                ser_par_nx = tx_buf[k*BITS +: BITS];
                            end
                        end
                    end
                end
                // Independent of next_ev so that coincident events are both applied.
                if (fin_ev && (rx_idx < word_count)) begin
                    for (int unsigned k = 0; k < MAX_WORDS; k++) begin
                        if (rx_idx == CW'(k)) begin
                            rx_data_nx[k*BITS +: BITS] = in_ser_parallel;
                        end
                    end
                    rx_idx_nx = rx_idx + CW'(1);
                end
                if ((rx_idx == word_count) && ready_sync[1]) begin
                    phase_cnt_nx = '0;
                    state_nx     = S_CS_HOLD;
                end
            end

            S_CS_HOLD: begin
                if (phase_cnt == TW'(CS_HOLD_CYCLES - 1)) begin
                    phase_cnt_nx = '0;
                    cs_nx        = ~CS_ACTIVE;
                    state_nx     = S_DONE;
                end else begin
                    phase_cnt_nx = phase_cnt + TW'(1);
                end
            end

            S_DONE: begin
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// tb_serial_xfer_ctrl
//   Directed bench for serial_xfer_ctrl with a behavioural serial block running on
//   its own slower clock (period 40 ns vs 10 ns main clock, fixed phase offset).
module tb_serial_xfer_ctrl;

    localparam int unsigned BITS      = 8;
    localparam int unsigned MAX_WORDS = 4;
    localparam int unsigned SETUP     = 5;
    localparam int unsigned HOLD      = 7;

    logic        clk = 1'b0;
    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  num_words = '0;
    logic [31:0] tx_data = '0;
    logic [31:0] rx_data;
    logic        busy, done, cs, ser_en;
    logic [7:0]  ser_par_o;
    logic        ser_ready = 1'b1;
    logic        ser_next = 1'b0;
    logic        ser_fin = 1'b0;
    logic [7:0]  ser_par_i = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    serial_xfer_ctrl #(
        .BITS(BITS), .MAX_WORDS(MAX_WORDS), .CS_SETUP_CYCLES(SETUP),
        .CS_HOLD_CYCLES(HOLD), .CS_ACTIVE(1'b0)
    ) dut (
        .in_clk(clk), .in_rst(rst_n), .in_start(start), .in_num_words(num_words),
        .in_tx_data(tx_data), .out_rx_data(rx_data), .out_busy(busy), .out_done(done),
        .out_cs(cs), .out_ser_enable(ser_en), .out_ser_parallel(ser_par_o),
        .in_ser_ready(ser_ready), .in_ser_next_word(ser_next),
        .in_ser_word_fin(ser_fin), .in_ser_parallel(ser_par_i)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #3;
        forever #20 sclk = ~sclk;
    end

    // Behavioural serial block: loads a word when enabled, pulses next_word at each
    // word load, shifts BITS bits MSB first, then pulses word_finished with the rx word.
    logic [7:0]  slave_resp [4];
    bit          loopback = 1'b0;
    bit          sm_busy = 1'b0;
    int unsigned sm_bit = 0;
    int unsigned sm_word = 0;
    int unsigned bit_cnt = 0;
    int unsigned sent_n = 0;
    logic [7:0]  sm_tx = '0, sm_resp = '0, sm_rx = '0, cur_sent = '0;
    logic [7:0]  sent_arr [64];
    logic        mosi, miso;

    always @(posedge sclk) begin
        ser_next <= 1'b0;
        ser_fin  <= 1'b0;
        if (!sm_busy) begin
            if (ser_en) begin
                sm_busy   = 1'b1;
                ser_ready <= 1'b0;
                sm_tx     = ser_par_o;
                sm_word   = 0;
                sm_resp   = slave_resp[0];
                sm_bit    = 0;
                ser_next  <= 1'b1;
            end
        end else begin
            mosi     = sm_tx[7];
            miso     = loopback ? mosi : sm_resp[7];
            sm_tx    = {sm_tx[6:0], 1'b0};
            sm_resp  = {sm_resp[6:0], 1'b0};
            cur_sent = {cur_sent[6:0], mosi};
            sm_rx    = {sm_rx[6:0], miso};
            bit_cnt++;
            sm_bit++;
            if (sm_bit == 8) begin
                ser_par_i <= sm_rx;
                ser_fin   <= 1'b1;
                if (sent_n < 64) sent_arr[sent_n] = cur_sent;
                sent_n++;
                if (ser_en) begin
                    sm_tx    = ser_par_o;
                    sm_word++;
                    sm_resp  = slave_resp[sm_word % 4];
                    sm_bit   = 0;
                    ser_next <= 1'b1;
                end else begin
                    sm_busy   = 1'b0;
                    ser_ready <= 1'b1;
                end
            end
        end
    end

    // Main-clock monitor: cumulative counters; tests look at deltas.
    int unsigned done_cnt = 0, cs_toggles = 0, en_rises = 0;
    int unsigned setup_win = 0, hold_win = 0, en_fall_word = 99;
    logic        cs_prev = 1'b1, en_prev = 1'b0;
    bit          en_seen = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (cs != cs_prev) cs_toggles++;
        if (ser_en && !en_prev) en_rises++;
        if (!ser_en && en_prev) en_fall_word = sm_word;
        if (cs) en_seen = 1'b0;
        else if (ser_en) en_seen = 1'b1;
        if (!cs && !ser_en && !en_seen) setup_win++;
        if (!cs && en_seen && !ser_en && ser_ready) hold_win++;
        cs_prev = cs;
        en_prev = ser_en;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [2:0] n, input logic [31:0] d);
        start     = 1'b1;
        num_words = n;
        tx_data   = d;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned base);
        int unsigned budget;
        budget = 3000;
        while (done_cnt == base && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(4);
        check_eq(tag, 64'(done_cnt - base), 64'd1);
    endtask

    int unsigned b_done, b_bits, b_sent, b_setup, b_hold, b_tog, b_rise;

    task automatic snap();
        b_done  = done_cnt;
        b_bits  = bit_cnt;
        b_sent  = sent_n;
        b_setup = setup_win;
        b_hold  = hold_win;
        b_tog   = cs_toggles;
        b_rise  = en_rises;
    endtask

    initial begin
        int unsigned budget;
        for (int unsigned i = 0; i < 4; i++) slave_resp[i] = '0;

        // Reset state
        tick(3);
        check_eq("rst_cs", 64'(cs), 64'd1);
        check_eq("rst_en", 64'(ser_en), 64'd0);
        check_eq("rst_par", 64'(ser_par_o), 64'd0);
        check_eq("rst_rx", 64'(rx_data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick(10);

        // 1: single word, slave answers 0x3C
        slave_resp[0] = 8'h3C;
        loopback = 1'b0;
        snap();
        pulse_start(3'd1, 32'h0000_00A5);
        tick(2);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_done", b_done);
        check_eq("t1_rx", 64'(rx_data), 64'h0000_003C);
        check_eq("t1_words", 64'(sent_n - b_sent), 64'd1);
        check_eq("t1_sent0", 64'(sent_arr[b_sent]), 64'hA5);
        check_eq("t1_bits", 64'(bit_cnt - b_bits), 64'd8);
        check_eq("t1_setup", 64'(setup_win - b_setup), 64'(SETUP));
        // ready edge -> 2 sync stages -> rx_idx update -> hold entry, then HOLD cycles
        check_eq("t1_hold", 64'(hold_win - b_hold), 64'(HOLD + 3));
        check_eq("t1_idle", 64'(busy), 64'd0);

        // 2: three words, loopback
        loopback = 1'b1;
        snap();
        pulse_start(3'd3, 32'h0033_2211);
        wait_done("t2_done", b_done);
        check_eq("t2_rx", 64'(rx_data), 64'h0033_2211);
        check_eq("t2_bits", 64'(bit_cnt - b_bits), 64'd24);
        check_eq("t2_words", 64'(sent_n - b_sent), 64'd3);
        check_eq("t2_sent1", 64'(sent_arr[b_sent + 1]), 64'h22);
        check_eq("t2_sent2", 64'(sent_arr[b_sent + 2]), 64'h33);
        check_eq("t2_en_drop_word", 64'(en_fall_word), 64'd2);
        check_eq("t2_setup", 64'(setup_win - b_setup), 64'(SETUP));

        // 3: zero words -> done without touching CS or enable
        snap();
        start = 1'b1;
        num_words = 3'd0;
        tick(1);
        start = 1'b0;
        check_eq("t3_done_c1", 64'(done), 64'd0);
        tick(1);
        check_eq("t3_done_c2", 64'(done), 64'd1);
        tick(1);
        check_eq("t3_done_c3", 64'(done), 64'd0);
        tick(10);
        check_eq("t3_cs_toggles", 64'(cs_toggles - b_tog), 64'd0);
        check_eq("t3_en_rises", 64'(en_rises - b_rise), 64'd0);
        check_eq("t3_done_cnt", 64'(done_cnt - b_done), 64'd1);

        // 4: seven words requested, clamped to four; start while busy ignored
        snap();
        pulse_start(3'd7, 32'hDDCC_BBAA);
        tick(20);
        pulse_start(3'd2, 32'h0101_0101);
        wait_done("t4_done", b_done);
        tick(30);
        check_eq("t4_single_done", 64'(done_cnt - b_done), 64'd1);
        check_eq("t4_rx", 64'(rx_data), 64'hDDCC_BBAA);
        check_eq("t4_words", 64'(sent_n - b_sent), 64'd4);
        check_eq("t4_bits", 64'(bit_cnt - b_bits), 64'd32);
        check_eq("t4_en_drop_word", 64'(en_fall_word), 64'd3);

        // 5: reset in the middle of word 1 of three
        snap();
        pulse_start(3'd3, 32'h0066_5544);
        budget = 2000;
        while (!(sm_busy && sm_word == 1 && sm_bit == 3) && budget > 0) begin
            #1;
            budget--;
        end
        check_eq("t5_reached_word1", 64'(budget > 0), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_cs_off", 64'(cs), 64'd1);
        check_eq("t5_en_off", 64'(ser_en), 64'd0);
        check_eq("t5_busy_off", 64'(busy), 64'd0);
        tick(5);
        rst_n = 1'b1;
        tick(60);
        check_eq("t5_no_done", 64'(done_cnt - b_done), 64'd0);
        check_eq("t5_rx_cleared", 64'(rx_data), 64'd0);
        loopback = 1'b0;
        slave_resp[0] = 8'h5A;
        snap();
        pulse_start(3'd1, 32'h0000_0077);
        wait_done("t5_fresh_done", b_done);
        check_eq("t5_fresh_rx", 64'(rx_data), 64'h0000_005A);
        check_eq("t5_fresh_sent", 64'(sent_arr[b_sent]), 64'h77);
        check_eq("t5_fresh_hold", 64'(hold_win - b_hold), 64'(HOLD + 3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
